mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one shift-add `multiplier` among NREQ requesters. It accepts operand pairs over a per-lane valid/ack handshake and issues one start pulse per job. It tracks the multiplier's ready handshake and returns each product, tagged with the requester id, as a single-cycle response. It sits between the requesting datapaths and the single multiplier instance; an operation timeout guards against a hung multiplier.

---
 rtl/mult_arbiter_if.sv | 35 +++
 rtl/mult_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals for mult_arbiter.
// The slave modport is the arbiter; master is whatever surrounds it.
interface mult_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ack;
    logic              resp_valid;
    logic [IW-1:0]     resp_id;
    logic [2*W-1:0]    resp_product;
    logic              resp_err;
    logic              busy;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic              mul_start;
    logic [2*W-1:0]    mul_product;
    logic              mul_ready;

    modport slave (
        input  req_valid, req_x, req_y, mul_product, mul_ready,
        output req_ack, resp_valid, resp_id, resp_product, resp_err, busy,
               mul_x, mul_y, mul_start
    );

    modport master (
        output req_valid, req_x, req_y, mul_product, mul_ready,
        input  req_ack, resp_valid, resp_id, resp_product, resp_err, busy,
               mul_x, mul_y, mul_start
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one shift-add multiplier among NREQ lanes,
// with a watchdog that aborts a job when the multiplier stops responding.
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 16
) (
    input logic          clk_in,
    input logic          rst_in,
    mult_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rrPtr_q, rrPtr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              start_q, start_d;
    logic              respValid_q, respValid_d;
    logic [IW-1:0]     respId_q, respId_d;
    logic [2*W-1:0]    respProduct_q, respProduct_d;
    logic              respErr_q, respErr_d;
    logic              busy_q, busy_d;
    logic [W-1:0]      mulX_q, mulX_d;
    logic [W-1:0]      mulY_q, mulY_d;

    logic              found;
    int                pick;

    // Scan lanes starting at the pointer so the last-served lane goes to the back.
    always_comb begin
        found = 1'b0;
        pick  = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(rrPtr_q) + k) % NREQ]) begin
                found = 1'b1;
                pick  = (int'(rrPtr_q) + k) % NREQ;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rrPtr_d       = rrPtr_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        start_d       = 1'b0;
        respValid_d   = 1'b0;
        respId_d      = respId_q;
        respProduct_d = respProduct_q;
        respErr_d     = respErr_q;
        mulX_d        = mulX_q;
        mulY_d        = mulY_q;

        case (state_q)
            IDLE: begin
                if (bus.mul_ready && found) begin
                    grant_d     = IW'(pick);
                    mulX_d      = bus.req_x[pick*W +: W];
                    mulY_d      = bus.req_y[pick*W +: W];
                    ack_d[pick] = 1'b1;
                    start_d     = 1'b1;
                    rrPtr_d     = IW'((pick + 1) % NREQ);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!bus.mul_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = WAIT_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    respValid_d   = 1'b1;
                    respId_d      = grant_q;
                    respProduct_d = '0;
                    respErr_d     = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A result arriving on the final counter cycle still wins.
                if (bus.mul_ready) begin
                    respValid_d   = 1'b1;
                    respId_d      = grant_q;
                    respProduct_d = bus.mul_product;
                    respErr_d     = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    respValid_d   = 1'b1;
                    respId_d      = grant_q;
                    respProduct_d = '0;
                    respErr_d     = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            rrPtr_q       <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            ack_q         <= '0;
            start_q       <= 1'b0;
            respValid_q   <= 1'b0;
            respId_q      <= '0;
            respProduct_q <= '0;
            respErr_q     <= 1'b0;
            busy_q        <= 1'b0;
            mulX_q        <= '0;
            mulY_q        <= '0;
        end else begin
            state_q       <= state_d;
            rrPtr_q       <= rrPtr_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            start_q       <= start_d;
            respValid_q   <= respValid_d;
            respId_q      <= respId_d;
            respProduct_q <= respProduct_d;
            respErr_q     <= respErr_d;
            busy_q        <= busy_d;
            mulX_q        <= mulX_d;
            mulY_q        <= mulY_d;
        end
    end

    assign bus.req_ack      = ack_q;
    assign bus.mul_start    = start_q;
    assign bus.resp_valid   = respValid_q;
    assign bus.resp_id      = respId_q;
    assign bus.resp_product = respProduct_q;
    assign bus.resp_err     = respErr_q;
    assign bus.busy         = busy_q;
    assign bus.mul_x        = mulX_q;
    assign bus.mul_y        = mulY_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier whose latency,
// hang behaviour and ready line can be steered by the stimulus.
module tb_mult_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 4;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    // Multiplier model: drops ready after taking start, raises it after mulLatency cycles.
    int         mulLatency = 4;
    logic       hangMode   = 1'b0;
    logic       holdLow    = 1'b0;
    logic       modelReady;
    logic       modelBusy;
    int         modelCnt;
    logic [7:0] modelProduct;
    logic [3:0] opX, opY;

    assign bus.mul_ready   = modelReady & ~holdLow;
    assign bus.mul_product = modelProduct;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelReady   <= 1'b1;
            modelBusy    <= 1'b0;
            modelCnt     <= 0;
            modelProduct <= 8'h00;
            opX          <= 4'h0;
            opY          <= 4'h0;
        end else if (!modelBusy) begin
            if (bus.mul_start) begin
                modelBusy  <= 1'b1;
                modelReady <= 1'b0;
                modelCnt   <= mulLatency;
                opX        <= bus.mul_x;
                opY        <= bus.mul_y;
            end
        end else if (!hangMode) begin
            if (modelCnt <= 1) begin
                modelReady   <= 1'b1;
                modelBusy    <= 1'b0;
                modelProduct <= {4'h0, opX} * {4'h0, opY};
            end else begin
                modelCnt <= modelCnt - 1;
            end
        end
    end

    int              checks = 0;
    int              errors = 0;
    int              cycleNum = 0;
    int              startCount = 0;
    int              startCycle = 0;
    logic [NREQ-1:0] keepLane = '0;
    int              ackLog[$];
    int              respIdLog[$];
    int              respProdLog[$];
    int              respErrLog[$];
    int              respCycleLog[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ackAt(input int i);
        return (i < ackLog.size()) ? ackLog[i] : -1;
    endfunction
    function automatic int respIdAt(input int i);
        return (i < respIdLog.size()) ? respIdLog[i] : -1;
    endfunction
    function automatic int respProdAt(input int i);
        return (i < respProdLog.size()) ? respProdLog[i] : -1;
    endfunction
    function automatic int respErrAt(input int i);
        return (i < respErrLog.size()) ? respErrLog[i] : -1;
    endfunction
    function automatic int respLatAt(input int i);
        return (i < respCycleLog.size()) ? respCycleLog[i] - startCycle : -1;
    endfunction

    // One clock step; also plays the requesters, which drop valid once acked.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cycleNum++;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ack[i]) begin
                ackLog.push_back(i);
                if (!keepLane[i]) bus.req_valid[i] = 1'b0;
            end
        end
        if (bus.mul_start) begin
            startCount++;
            startCycle = cycleNum;
        end
        if (bus.resp_valid) begin
            respIdLog.push_back(int'(bus.resp_id));
            respProdLog.push_back(int'(bus.resp_product));
            respErrLog.push_back(int'(bus.resp_err));
            respCycleLog.push_back(cycleNum);
        end
    endtask

    task automatic clearLogs();
        ackLog.delete();
        respIdLog.delete();
        respProdLog.delete();
        respErrLog.delete();
        respCycleLog.delete();
        startCount = 0;
    endtask

    task automatic applyStimulus(input int lane, input logic [3:0] x, input logic [3:0] y);
        bus.req_x[lane*W +: W] = x;
        bus.req_y[lane*W +: W] = y;
        bus.req_valid[lane]    = 1'b1;
    endtask

    task automatic applyReset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        keepLane      = '0;
        holdLow       = 1'b0;
        hangMode      = 1'b0;
        mulLatency    = 4;
        repeat (2) stepCycle();
        rst_n = 1'b1;
        stepCycle();
        clearLogs();
    endtask

    task automatic waitAcks(input int n, input int budget);
        for (int c = 0; c < budget && ackLog.size() < n; c++) stepCycle();
        checkOutput("ackCount", ackLog.size(), n);
    endtask

    task automatic waitResps(input int n, input int budget);
        for (int c = 0; c < budget && respIdLog.size() < n; c++) stepCycle();
        checkOutput("respCount", respIdLog.size(), n);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetAll", {bus.req_ack, bus.resp_valid, bus.resp_id, bus.resp_product,
                                 bus.resp_err, bus.busy, bus.mul_x, bus.mul_y, bus.mul_start}, 0);
        rst_n = 1'b1;
        stepCycle();
        clearLogs();

        // Single job, B*D with latency 4.
        applyStimulus(0, 4'hB, 4'hD);
        waitResps(1, 30);
        checkOutput("singleAckCnt", ackLog.size(), 1);
        checkOutput("singleAckLane", ackAt(0), 0);
        checkOutput("singleStarts", startCount, 1);
        checkOutput("singleId", respIdAt(0), 0);
        checkOutput("singleProd", respProdAt(0), 32'h8F);
        checkOutput("singleErr", respErrAt(0), 0);
        checkOutput("singleLatency", respLatAt(0), 6);
        stepCycle();
        checkOutput("singleIdleBusy", bus.busy, 0);
        checkOutput("singleNoRepeat", respIdLog.size(), 1);

        // Lanes 1 and 3 together, then lanes 0 and 1 with the pointer back at 0.
        applyReset();
        applyStimulus(1, 4'h2, 4'h3);
        applyStimulus(3, 4'h4, 4'h5);
        waitResps(2, 40);
        checkOutput("pairAck0", ackAt(0), 1);
        checkOutput("pairAck1", ackAt(1), 3);
        checkOutput("pairId0", respIdAt(0), 1);
        checkOutput("pairProd0", respProdAt(0), 6);
        checkOutput("pairId1", respIdAt(1), 3);
        checkOutput("pairProd1", respProdAt(1), 20);
        clearLogs();
        applyStimulus(1, 4'h1, 4'h1);
        applyStimulus(0, 4'h2, 4'h2);
        waitResps(2, 40);
        checkOutput("wrapAck0", ackAt(0), 0);
        checkOutput("wrapAck1", ackAt(1), 1);
        checkOutput("wrapProd0", respProdAt(0), 4);
        checkOutput("wrapProd1", respProdAt(1), 1);

        // All four lanes requesting without letting go.
        applyReset();
        keepLane = '1;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 4'(i + 1), 4'h3);
        waitAcks(5, 80);
        bus.req_valid = '0;
        keepLane      = '0;
        waitResps(5, 40);
        for (int k = 0; k < 5; k++) checkOutput("rrOrder", ackAt(k), k % NREQ);
        for (int k = 0; k < NREQ; k++) begin
            checkOutput("rrId", respIdAt(k), k);
            checkOutput("rrProd", respProdAt(k), 3 * (k + 1));
        end

        // Hung multiplier: abort after the watchdog, then serve the next lane.
        clearLogs();
        hangMode = 1'b1;
        applyStimulus(2, 4'h5, 4'h5);
        waitResps(1, 40);
        checkOutput("toErr", respErrAt(0), 1);
        checkOutput("toProd", respProdAt(0), 0);
        checkOutput("toId", respIdAt(0), 2);
        checkOutput("toLatency", respLatAt(0), TIMEOUT + 1);
        hangMode = 1'b0;
        clearLogs();
        applyStimulus(3, 4'h2, 4'h7);
        waitResps(1, 40);
        checkOutput("afterToProd", respProdAt(0), 14);
        checkOutput("afterToErr", respErrAt(0), 0);
        checkOutput("afterToId", respIdAt(0), 3);

        // Multiplier not ready: no grant until ready returns.
        clearLogs();
        holdLow = 1'b1;
        applyStimulus(2, 4'h3, 4'h4);
        repeat (4) stepCycle();
        checkOutput("holdNoAck", ackLog.size(), 0);
        checkOutput("holdNoStart", startCount, 0);
        holdLow = 1'b0;
        stepCycle();
        checkOutput("holdAckNow", bus.req_ack, 4'b0100);
        checkOutput("holdStartNow", bus.mul_start, 1);
        waitResps(1, 30);
        checkOutput("holdProd", respProdAt(0), 12);

        // Reset while waiting for the product.
        clearLogs();
        mulLatency = 8;
        applyStimulus(1, 4'h7, 4'h3);
        for (int c = 0; c < 20 && startCount == 0; c++) stepCycle();
        checkOutput("midStart", startCount, 1);
        repeat (3) stepCycle();
        checkOutput("midBusy", bus.busy, 1);
        checkOutput("midMulX", bus.mul_x, 4'h7);
        checkOutput("midMulY", bus.mul_y, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetAll", {bus.req_ack, bus.resp_valid, bus.resp_id, bus.resp_product,
                                      bus.resp_err, bus.busy, bus.mul_x, bus.mul_y, bus.mul_start}, 0);
        bus.req_valid = '0;
        repeat (2) stepCycle();
        rst_n      = 1'b1;
        mulLatency = 4;
        repeat (15) stepCycle();
        checkOutput("noStaleResp", respIdLog.size(), 0);
        clearLogs();
        applyStimulus(0, 4'hF, 4'hF);
        waitResps(1, 30);
        checkOutput("freshProd", respProdAt(0), 32'hE1);
        checkOutput("freshId", respIdAt(0), 0);
        checkOutput("freshErr", respErrAt(0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
